piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits (WIDTH >= 2).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted out first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pi  input  WIDTH  parallel word to transmit.
REQ-006 load_valid  input  1  pi holds a word to send.
REQ-007 load_ready  output  1  block accepts pi this cycle.
REQ-008 so  output  1  serial data out, registered.
REQ-009 so_valid  output  1  so carries a frame bit this cycle.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-012 The word SHALL be accepted on a rising edge where load_valid && load_ready; pi is captured into an internal shift register that edge.
REQ-013 First frame bit SHALL appear on so with so_valid=1 in the cycle after acceptance; latency = 1 cycle.
REQ-014 Data bits SHALL be presented one per cycle for exactly WIDTH consecutive cycles, order per MSB_FIRST.
REQ-015 FSM states SHALL be IDLE, SHIFT, PAR (PAR exists only with parity enabled); IDLE->SHIFT on accept; SHIFT->IDLE after bit WIDTH (or SHIFT->PAR when parity enabled); PAR->IDLE after one cycle.
REQ-016 A bit counter SHALL count 0..WIDTH-1 in SHIFT and wrap to 0 on frame end.
REQ-017 done SHALL be 1 exactly in the cycle the final frame bit is on so, 0 otherwise.
REQ-018 busy SHALL be 1 whenever so_valid is 1.
REQ-019 load_ready SHALL be 1 in IDLE and in the final-bit cycle, 0 otherwise.
REQ-020 Accept during the final-bit cycle SHALL start the next frame in the following cycle with no gap (so_valid stays 1).
REQ-021 load_valid while load_ready=0 SHALL be ignored; pi changes mid-frame SHALL not affect the frame.
REQ-022 In IDLE with no accept, so=0, so_valid=0, busy=0.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, shift register 0, so=0, so_valid=0, busy=0, done=0, load_ready=1 (after release).
REQ-024 rst asserted mid-frame SHALL abort the frame with no done pulse; first accept after release starts a fresh frame.

Configuration
REQ-025 Macro PISO_TX_PARITY_EN SHALL, when defined, append one even-parity bit (XOR of all WIDTH data bits) after the data bits via state PAR; frame length WIDTH+1, done on the parity bit.
REQ-026 Without PISO_TX_PARITY_EN, frame length SHALL be WIDTH, state PAR and parity logic SHALL be absent.

Structure
REQ-027 Shared package shift_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, PAR) and the default width constant 4.
REQ-028 Bit counter SHALL be sub-module bit_counter (parameter WIDTH, inputs clk, rst, en, output count and last-bit flag).

Verification (WIDTH=4)
REQ-029 Reset, then load 4'b0101, MSB_FIRST=1 -> so = 0,1,0,1 on cycles 1-4 after accept, so_valid=1 cycles 1-4, done on cycle 4 only.
REQ-030 MSB_FIRST=0, load 4'b0011 -> so = 1,1,0,0; done on cycle 4.
REQ-031 Load 4'b1000, hold load_valid with 4'b0011 ready at final bit -> 8 consecutive so_valid cycles: 1,0,0,0,0,0,1,1; two done pulses (cycles 4 and 8).
REQ-032 Load 4'b0111, drive pi=4'b0000 with load_valid=1 mid-frame -> so = 0,1,1,1 unchanged; second word accepted only at final bit.
REQ-033 Load 4'b0101, assert rst in cycle 2 -> so=0, so_valid=0, busy=0 immediately, no done; after release, load 4'b1000 -> so = 1,0,0,0.
REQ-034 With PISO_TX_PARITY_EN: load 4'b0101 -> 0,1,0,1,0; load 4'b1000 -> 1,0,0,0,1; done on 5th bit each.

Source files
------------

// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package    : shift_pkg
// Description: Shared definitions for the piso_tx serializer: FSM state
//              encoding, default word width and a counter-width helper.
//              PAR state is present only when PISO_TX_PARITY_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_TX_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_e;

  // Bits needed to index WIDTH positions (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Interface  : piso_tx_if
// Description: Load handshake and serial output bundle of piso_tx.
//              master = word source / serial consumer, slave = serializer.
// Revision   : 1.0 - initial release
// ============================================================================
interface piso_tx_if
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  modport master (
    output pi, load_valid,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  pi, load_valid,
    output load_ready, so, so_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_tx_bit_counter.sv
`default_nettype none
// ============================================================================
// Module     : bit_counter
// Description: Frame bit index. Counts 0..WIDTH-1 while en is high and wraps
//              to 0 after the last position; last flags index WIDTH-1.
// Revision   : 1.0 - initial release
// ============================================================================
module bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [cnt_width(WIDTH)-1:0]  count,
  output logic                         last
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q;

  // Advance one position per enabled cycle, wrapping at the last data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      if (last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(WIDTH - 1));
endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module     : piso_tx
// Description: Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on
//              a valid/ready handshake and emits it one bit per cycle, MSB or
//              LSB first. A new word may be accepted on the final bit so that
//              frames run back to back. Define PISO_TX_PARITY_EN to append an
//              even-parity bit to every frame.
// Revision   : 1.0 - initial release
// ============================================================================
module piso_tx
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e            state_q;
  logic [WIDTH-1:0]  sr_q;
  logic              so_q;
  logic              so_valid_q;
  logic              busy_q;
  logic              done_q;
`ifdef PISO_TX_PARITY_EN
  logic              par_q;
`endif

  logic [CW-1:0]     w_count;
  logic              w_last;
  logic              w_accept;
  logic              w_first_bit;
  logic              w_next_bit;
  logic [WIDTH-1:0]  w_load_sr;
  logic [WIDTH-1:0]  w_shift_sr;
`ifndef PISO_TX_PARITY_EN
  logic              w_pre_last;
`endif

  // The first bit goes straight to so at accept; sr_q holds the remaining
  // bits already aligned so the next one always sits at the exit position.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit = bus.pi[WIDTH-1];
      assign w_load_sr   = {bus.pi[WIDTH-2:0], 1'b0};
      assign w_next_bit  = sr_q[WIDTH-1];
      assign w_shift_sr  = {sr_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit = bus.pi[0];
      assign w_load_sr   = {1'b0, bus.pi[WIDTH-1:1]};
      assign w_next_bit  = sr_q[0];
      assign w_shift_sr  = {1'b0, sr_q[WIDTH-1:1]};
    end
  endgenerate

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == SHIFT),
    .count (w_count),
    .last  (w_last)
  );

  // Ready in IDLE and on the final frame bit, which is exactly when done_q is set.
  assign w_accept = bus.load_valid && bus.load_ready;

`ifndef PISO_TX_PARITY_EN
  // The bit about to be shifted out next is the last data bit.
  assign w_pre_last = (w_count == CW'(WIDTH - 2));
`endif

  // Frame sequencer: load on accept, shift one bit per cycle, close on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (w_accept) begin
      state_q    <= SHIFT;
      sr_q       <= w_load_sr;
      so_q       <= w_first_bit;
      so_valid_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q      <= ^bus.pi;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!w_last) begin
            so_q <= w_next_bit;
            sr_q <= w_shift_sr;
`ifdef PISO_TX_PARITY_EN
            done_q <= 1'b0;
`else
            done_q <= w_pre_last;
`endif
          end else begin
`ifdef PISO_TX_PARITY_EN
            state_q <= PAR;
            so_q    <= par_q;
            done_q  <= 1'b1;
`else
            state_q    <= IDLE;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`endif
          end
        end
        // IDLE, and the parity cycle ending without a follow-on word.
        default: begin
          state_q    <= IDLE;
          so_q       <= 1'b0;
          so_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.so         = so_q;
  assign bus.so_valid   = so_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = (state_q == IDLE) || done_q;
endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module     : tb_piso_tx
// Description: Directed self-checking bench for piso_tx, WIDTH=4, one MSB-first
//              and one LSB-first instance. Honors PISO_TX_PARITY_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  piso_tx_if #(.WIDTH(W)) bm ();
  piso_tx_if #(.WIDTH(W)) bl ();

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] obs;
    logic [4:0] obs5;
    rst = 1'b1;
    bm.pi = '0; bm.load_valid = 1'b0;
    bl.pi = '0; bl.load_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done};
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_msb: got so/vld/busy/done=%b expected 0000", obs); end
    obs = {bl.so, bl.so_valid, bl.busy, bl.done};
    n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_lsb: got so/vld/busy/done=%b expected 0000", obs); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    obs5 = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs5 !== 5'b00001) begin n_err++; $display("FAIL post_reset_msb: got so/vld/busy/done/rdy=%b expected 00001", obs5); end
    obs5 = {bl.so, bl.so_valid, bl.busy, bl.done, bl.load_ready};
    n_cmp++; if (obs5 !== 5'b00001) begin n_err++; $display("FAIL post_reset_lsb: got so/vld/busy/done/rdy=%b expected 00001", obs5); end
  endtask

  task automatic test_msb_basic();
    logic [0:4] exp_so;
    logic [4:0] obs, exp;
    exp_so = 5'b01010;  // 0101 then parity 0
    @(posedge clk); #1; bm.pi = 4'b0101; bm.load_valid = 1'b1;
    @(posedge clk); #1; bm.load_valid = 1'b0; bm.pi = 4'b1111;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
      exp = {exp_so[c-1], 1'b1, 1'b1, (c == FL), (c == FL)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL msb_0101 cycle %0d: got so/vld/busy/done/rdy=%b expected %b", c, obs, exp); end
    end
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL msb_0101 idle: got %b expected 00001", obs); end
  endtask

  task automatic test_lsb_first();
    logic [0:4] exp_so;
    logic [4:0] obs, exp;
    exp_so = 5'b11000;  // 0011 LSB first then parity 0
    @(posedge clk); #1; bl.pi = 4'b0011; bl.load_valid = 1'b1;
    @(posedge clk); #1; bl.load_valid = 1'b0; bl.pi = 4'b0000;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      obs = {bl.so, bl.so_valid, bl.busy, bl.done, bl.load_ready};
      exp = {exp_so[c-1], 1'b1, 1'b1, (c == FL), (c == FL)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL lsb_0011 cycle %0d: got so/vld/busy/done/rdy=%b expected %b", c, obs, exp); end
    end
    @(negedge clk);
    obs = {bl.so, bl.so_valid, bl.busy, bl.done, bl.load_ready};
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL lsb_0011 idle: got %b expected 00001", obs); end
  endtask

  task automatic test_back_to_back();
    logic [0:9] exp_so;
    logic [4:0] obs, exp;
`ifdef PISO_TX_PARITY_EN
    exp_so = 10'b10001_00110;
`else
    exp_so = 10'b1000_0011_00;
`endif
    @(posedge clk); #1; bm.pi = 4'b1000; bm.load_valid = 1'b1;
    @(posedge clk); #1; bm.pi = 4'b0011;
    for (int c = 1; c <= 2*FL; c++) begin
      @(negedge clk);
      obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
      exp = {exp_so[c-1], 1'b1, 1'b1, (c == FL || c == 2*FL), (c == FL || c == 2*FL)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b cycle %0d: got so/vld/busy/done/rdy=%b expected %b", c, obs, exp); end
      if (c == FL) begin
        @(posedge clk); #1; bm.load_valid = 1'b0;
      end
    end
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL b2b idle: got %b expected 00001", obs); end
  endtask

  task automatic test_midframe_ignore();
    logic [0:9] exp_so;
    logic [4:0] obs, exp;
`ifdef PISO_TX_PARITY_EN
    exp_so = 10'b01111_00000;
`else
    exp_so = 10'b0111_0000_00;
`endif
    @(posedge clk); #1; bm.pi = 4'b0111; bm.load_valid = 1'b1;
    @(posedge clk); #1; bm.pi = 4'b0000;
    for (int c = 1; c <= 2*FL; c++) begin
      @(negedge clk);
      obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
      exp = {exp_so[c-1], 1'b1, 1'b1, (c == FL || c == 2*FL), (c == FL || c == 2*FL)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL midframe cycle %0d: got so/vld/busy/done/rdy=%b expected %b", c, obs, exp); end
      if (c == FL) begin
        @(posedge clk); #1; bm.load_valid = 1'b0;
      end
    end
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL midframe idle: got %b expected 00001", obs); end
  endtask

  task automatic test_reset_midframe();
    logic [0:4] exp_so;
    logic [3:0] obs4;
    logic [4:0] obs, exp;
    exp_so = 5'b10001;  // 1000 then parity 1
    @(posedge clk); #1; bm.pi = 4'b0101; bm.load_valid = 1'b1;
    @(posedge clk); #1; bm.load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs !== 5'b11100) begin n_err++; $display("FAIL rstmid cycle2: got so/vld/busy/done/rdy=%b expected 11100", obs); end
    #1; rst = 1'b1;
    #1;
    obs4 = {bm.so, bm.so_valid, bm.busy, bm.done};
    n_cmp++; if (obs4 !== 4'b0000) begin n_err++; $display("FAIL rstmid async: got so/vld/busy/done=%b expected 0000", obs4); end
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
      n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL rstmid idle %0d: got %b expected 00001", c, obs); end
    end
    @(posedge clk); #1; bm.pi = 4'b1000; bm.load_valid = 1'b1;
    @(posedge clk); #1; bm.load_valid = 1'b0;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
      exp = {exp_so[c-1], 1'b1, 1'b1, (c == FL), (c == FL)};
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rstmid_1000 cycle %0d: got so/vld/busy/done/rdy=%b expected %b", c, obs, exp); end
    end
    @(negedge clk);
    obs = {bm.so, bm.so_valid, bm.busy, bm.done, bm.load_ready};
    n_cmp++; if (obs !== 5'b00001) begin n_err++; $display("FAIL rstmid_1000 idle: got %b expected 00001", obs); end
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_first();
    test_back_to_back();
    test_midframe_ignore();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
